// File: rtl/mcmc_move_commit.sv
// ---------------------------------------------------------------------------
// mcmc_move_commit
//
// Commit stage of the probabilistic search datapath. Each accept/reject
// decision arrives with its proposed assignment and failed-constraint count;
// accepted moves are written into the current-assignment registers, which
// feed the next round's "before move" inputs. The stage bounds the search
// with an iteration counter, recognises a solved state (zero failed
// constraints) and can optionally remember the best assignment seen.
//
// Optional feature macro: MCMC_BEST_TRACKING_EN
//   defined   -> best_* are registers updated on strictly better accepted moves
//   undefined -> best_* simply mirror current_*
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start               pulse: load init_* and max_iterations, begin a run
//   init_bool/int/failed  initial assignment and its failed-constraint count
//   max_iterations      move limit, 0 = unbounded
//   move_valid/ready    move handshake (ready only while running)
//   move_decision       1 = accept proposed move, 0 = reject
//   proposed_*          assignment and failed count after the move
//   current_*           committed assignment
//   best_*              best assignment seen
//   iteration_count     handshakes since start (saturating)
//   busy, done, solved  run status
// ---------------------------------------------------------------------------
module mcmc_move_commit #(
    parameter int NUM_BOOL   = 8,
    parameter int NUM_INT    = 4,
    parameter int INT_WIDTH  = 8,
    parameter int FAIL_WIDTH = 6,
    parameter int ITER_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_BOOL-1:0]          init_bool,
    input  logic [NUM_INT*INT_WIDTH-1:0] init_int,
    input  logic [FAIL_WIDTH-1:0]        init_failed,
    input  logic [ITER_WIDTH-1:0]        max_iterations,
    input  logic                         move_valid,
    output logic                         move_ready,
    input  logic                         move_decision,
    input  logic [NUM_BOOL-1:0]          proposed_bool,
    input  logic [NUM_INT*INT_WIDTH-1:0] proposed_int,
    input  logic [FAIL_WIDTH-1:0]        proposed_failed,
    output logic [NUM_BOOL-1:0]          current_bool,
    output logic [NUM_INT*INT_WIDTH-1:0] current_int,
    output logic [FAIL_WIDTH-1:0]        current_failed,
    output logic [NUM_BOOL-1:0]          best_bool,
    output logic [NUM_INT*INT_WIDTH-1:0] best_int,
    output logic [FAIL_WIDTH-1:0]        best_failed,
    output logic [ITER_WIDTH-1:0]        iteration_count,
    output logic                         busy,
    output logic                         done,
    output logic                         solved
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ITER_WIDTH-1:0]   max_iter_q;
    logic                    handshake;
    logic [FAIL_WIDTH-1:0]   commit_failed;
    logic [ITER_WIDTH-1:0]   iter_inc;
    logic                    limit_hit;

    assign handshake     = move_valid & move_ready;
    // A rejected move leaves the old count in place, so only an accepted
    // zero-fail proposal can solve the problem.
    assign commit_failed = move_decision ? proposed_failed : current_failed;
    assign iter_inc      = (&iteration_count) ? iteration_count
                                              : iteration_count + ITER_WIDTH'(1);
    assign limit_hit     = (max_iter_q != '0) && (iter_inc == max_iter_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start overrides everything, including a move
    // presented in the same cycle. Solved takes precedence over the limit.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (init_failed == '0) ? DONE : RUN;
        end else if (state == RUN && handshake) begin
            if (commit_failed == '0) begin
                state_next = DONE;
            end else if (limit_hit) begin
                state_next = DONE;
            end
        end
    end

    // Output decode; derived purely from the state register
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        move_ready = 1'b0;
        case (state)
            RUN: begin
                busy       = 1'b1;
                move_ready = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Committed assignment, iteration counter, limit and solved flag
    always_ff @(posedge clk) begin
        if (reset) begin
            current_bool    <= '0;
            current_int     <= '0;
            current_failed  <= '0;
            iteration_count <= '0;
            max_iter_q      <= '0;
            solved          <= 1'b0;
        end else if (start) begin
            current_bool    <= init_bool;
            current_int     <= init_int;
            current_failed  <= init_failed;
            iteration_count <= '0;
            max_iter_q      <= max_iterations;
            solved          <= (init_failed == '0);
        end else if (handshake) begin
            iteration_count <= iter_inc;
            if (move_decision) begin
                current_bool   <= proposed_bool;
                current_int    <= proposed_int;
                current_failed <= proposed_failed;
            end
            if (commit_failed == '0) begin
                solved <= 1'b1;
            end
        end
    end

`ifdef MCMC_BEST_TRACKING_EN
    // Best-so-far registers; strict comparison so ties keep the older one
    always_ff @(posedge clk) begin
        if (reset) begin
            best_bool   <= '0;
            best_int    <= '0;
            best_failed <= '0;
        end else if (start) begin
            best_bool   <= init_bool;
            best_int    <= init_int;
            best_failed <= init_failed;
        end else if (handshake && move_decision && (proposed_failed < best_failed)) begin
            best_bool   <= proposed_bool;
            best_int    <= proposed_int;
            best_failed <= proposed_failed;
        end
    end
`else
    assign best_bool   = current_bool;
    assign best_int    = current_int;
    assign best_failed = current_failed;
`endif

endmodule
